// File: rtl/uart_tx_frame_fsm.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Every state change is paced by the baud tick except the byte handshake in INTERVAL.
module uart_tx_frame_fsm #(
  parameter int IDLE_BAUDS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_BaudSig_i,
  input  logic [7:0] Data_i,
  input  logic       DataValid_i,
  output logic       DataReady_o,
  input  logic       ParityEnable_i,
  input  logic       ParityResult_i,
  output logic [4:0] State_o,
  output logic [7:0] TxData_o,
  output logic       p_ParityCalTrigger_o,
  output logic [3:0] BitCounter_o,
  output logic       Tx_o,
  output logic       p_FrameDone_o
);

  // state     | meaning
  // INTERVAL  | line idle; counting idle bauds, accepting a byte
  // STARTBIT  | line driven low for one baud
  // DATABITS  | shifting 8 data bits out, LSB first
  // PARITYBIT | parity bit from external generator
  // STOPBIT   | line high for one baud, then frame done
  typedef enum logic [4:0] {
    S_INTERVAL = 5'b00001,
    S_START    = 5'b00010,
    S_DATA     = 5'b00100,
    S_PARITY   = 5'b01000,
    S_STOP     = 5'b10000
  } state_t;

  localparam int CW = (IDLE_BAUDS < 2) ? 1 : $clog2(IDLE_BAUDS + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_BAUDS);

  state_t          r_state, w_state_nxt;
  logic            r_pending, w_pending_nxt;
  logic [CW-1:0]   r_idle_cnt, w_idle_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_txdata, w_txdata_nxt;
  logic            r_par_en, w_par_en_nxt;
  logic [3:0]      r_bitcnt, w_bitcnt_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_par_trig, w_par_trig_nxt;
  logic            r_done, w_done_nxt;
  logic            w_hs;

  assign w_hs = DataValid_i & r_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_idle_nxt     = r_idle_cnt;
    w_shift_nxt    = r_shift;
    w_txdata_nxt   = r_txdata;
    w_par_en_nxt   = r_par_en;
    w_bitcnt_nxt   = r_bitcnt;
    w_par_trig_nxt = 1'b0;
    w_done_nxt     = 1'b0;

    // Ready implies INTERVAL with nothing pending, so this never collides with shifting.
    if (w_hs) begin
      w_txdata_nxt  = Data_i;
      w_shift_nxt   = Data_i;
      w_par_en_nxt  = ParityEnable_i;
      w_pending_nxt = 1'b1;
    end

    case (r_state)
      S_INTERVAL: begin
        if (p_BaudSig_i) begin
          if (r_pending && (r_idle_cnt == IDLE_MAX)) begin
            w_state_nxt = S_START;
          end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_nxt = r_idle_cnt + 1'b1;
          end
        end
      end
      S_START: begin
        if (p_BaudSig_i) begin
          w_state_nxt    = S_DATA;
          w_bitcnt_nxt   = 4'd0;
          w_par_trig_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (p_BaudSig_i) begin
          if (r_bitcnt == 4'd7) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_shift_nxt  = r_shift >> 1;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (p_BaudSig_i) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (p_BaudSig_i) begin
          w_state_nxt   = S_INTERVAL;
          w_pending_nxt = 1'b0;
          w_idle_nxt    = '0;
          w_bitcnt_nxt  = 4'd0;
          w_done_nxt    = 1'b1;
        end
      end
      default: begin
        // corrupted state: drop any pending byte and return to a quiet line
        w_state_nxt   = S_INTERVAL;
        w_pending_nxt = 1'b0;
        w_idle_nxt    = '0;
        w_bitcnt_nxt  = 4'd0;
      end
    endcase

    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = ParityResult_i;
      default:  w_tx_nxt = 1'b1;
    endcase

    w_ready_nxt = (w_state_nxt == S_INTERVAL) && !w_pending_nxt && (w_idle_nxt == IDLE_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_INTERVAL;
      r_pending  <= 1'b0;
      r_idle_cnt <= '0;
      r_shift    <= 8'h00;
      r_txdata   <= 8'h00;
      r_par_en   <= 1'b0;
      r_bitcnt   <= 4'd0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b0;
      r_par_trig <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_shift    <= w_shift_nxt;
      r_txdata   <= w_txdata_nxt;
      r_par_en   <= w_par_en_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_tx       <= w_tx_nxt;
      r_ready    <= w_ready_nxt;
      r_par_trig <= w_par_trig_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign State_o              = r_state;
  assign DataReady_o          = r_ready;
  assign TxData_o             = r_txdata;
  assign p_ParityCalTrigger_o = r_par_trig;
  assign BitCounter_o         = r_bitcnt;
  assign Tx_o                 = r_tx;
  assign p_FrameDone_o        = r_done;

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// Bench for uart_tx_frame_fsm: expected frames are queued at handshake and
// compared bit by bit, per baud, by a line monitor.
module tb_uart_tx_frame_fsm;

  localparam int IDLE_BAUDS = 1;
  localparam int DIV        = 8;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_STRT = 5'b00010;
  localparam logic [4:0] ST_DATA = 5'b00100;
  localparam logic [4:0] ST_PAR  = 5'b01000;
  localparam logic [4:0] ST_STOP = 5'b10000;

  logic       clk;
  logic       rst;
  logic       p_BaudSig_i;
  logic [7:0] Data_i;
  logic       DataValid_i;
  logic       DataReady_o;
  logic       ParityEnable_i;
  logic       ParityResult_i;
  logic [4:0] State_o;
  logic [7:0] TxData_o;
  logic       p_ParityCalTrigger_o;
  logic [3:0] BitCounter_o;
  logic       Tx_o;
  logic       p_FrameDone_o;

  uart_tx_frame_fsm #(.IDLE_BAUDS(IDLE_BAUDS)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .p_BaudSig_i         (p_BaudSig_i),
    .Data_i              (Data_i),
    .DataValid_i         (DataValid_i),
    .DataReady_o         (DataReady_o),
    .ParityEnable_i      (ParityEnable_i),
    .ParityResult_i      (ParityResult_i),
    .State_o             (State_o),
    .TxData_o            (TxData_o),
    .p_ParityCalTrigger_o(p_ParityCalTrigger_o),
    .BitCounter_o        (BitCounter_o),
    .Tx_o                (Tx_o),
    .p_FrameDone_o       (p_FrameDone_o)
  );

  typedef struct {
    logic [10:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     done_count = 0;
  bit     in_frame = 0;

  // monitor state
  logic       mon_b;
  int         mon_n, mon_gap, mon_done, mon_trig;
  logic       got_tx [0:11];
  logic [4:0] got_st [0:11];
  logic [3:0] got_bc [0:11];
  frame_t     mon_e;
  int         baud_div = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    p_BaudSig_i = 1'b0;
    forever begin
      @(negedge clk);
      baud_div    = (baud_div == DIV - 1) ? 0 : baud_div + 1;
      p_BaudSig_i = (baud_div == 0);
    end
  end

  function automatic frame_t build_frame(input logic [7:0] d, input logic pe, input logic pr);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
    if (pe) begin
      f.bits[9] = pr;
      f.len     = 11;
    end else begin
      f.len = 10;
    end
    return f;
  endfunction

  function automatic logic [4:0] exp_state(input int i, input int len);
    if (i == 0) return ST_STRT;
    if (i <= 8) return ST_DATA;
    if (i == len - 1) return ST_STOP;
    return ST_PAR;
  endfunction

  // Line monitor: one sample per baud, taken on the falling edge after it.
  initial begin
    mon_n = 0; mon_gap = 0; mon_done = 0; mon_trig = 0;
    forever begin
      @(posedge clk);
      mon_b = p_BaudSig_i;
      @(negedge clk);
      if (!rst) begin
        in_frame = 0;
        mon_gap  = 0;
      end else begin
        if (p_FrameDone_o) begin
          done_count++;
          mon_done++;
        end
        if (p_ParityCalTrigger_o) mon_trig++;
        if (mon_b) begin
          if (!in_frame && State_o == ST_STRT) begin
            in_frame = 1; mon_n = 0; mon_done = 0; mon_trig = 0;
            checks++;
            if (mon_gap < IDLE_BAUDS) begin
              failures++;
              $display("FAIL idle_gap: got %0d idle bauds, need >= %0d", mon_gap, IDLE_BAUDS);
            end
          end
          if (in_frame) begin
            if (State_o == ST_IDLE) begin
              in_frame = 0;
              mon_gap  = 0;
              checks++;
              if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame: got %0d bits, none expected", mon_n);
              end else begin
                mon_e = exp_q.pop_front();
                if (mon_n !== mon_e.len) begin
                  failures++;
                  $display("FAIL frame_len: got %0d, expected %0d", mon_n, mon_e.len);
                end
                for (int i = 0; i < mon_n && i < mon_e.len; i++) begin
                  checks++;
                  if (got_tx[i] !== mon_e.bits[i]) begin
                    failures++;
                    $display("FAIL tx_bit[%0d]: got %b, expected %b", i, got_tx[i], mon_e.bits[i]);
                  end
                  checks++;
                  if (got_st[i] !== exp_state(i, mon_e.len)) begin
                    failures++;
                    $display("FAIL state[%0d]: got %b, expected %b", i, got_st[i], exp_state(i, mon_e.len));
                  end
                  if (i >= 1 && i <= 8) begin
                    checks++;
                    if (got_bc[i] !== 4'(i - 1)) begin
                      failures++;
                      $display("FAIL bitcnt[%0d]: got %0d, expected %0d", i, got_bc[i], i - 1);
                    end
                  end
                end
              end
              checks++;
              if (mon_done !== 1) begin
                failures++;
                $display("FAIL frame_done_count: got %0d, expected 1", mon_done);
              end
              checks++;
              if (mon_trig !== 1) begin
                failures++;
                $display("FAIL parity_trig_count: got %0d, expected 1", mon_trig);
              end
            end else if (mon_n < 12) begin
              got_tx[mon_n] = Tx_o;
              got_st[mon_n] = State_o;
              got_bc[mon_n] = BitCounter_o;
              mon_n++;
            end
          end else if (State_o == ST_IDLE) begin
            mon_gap++;
          end
        end
      end
    end
  end

  task automatic handshake(input logic [7:0] d, input logic pe, input logic pr,
                           input bit keep_valid, input bit push);
    int k;
    @(negedge clk);
    Data_i         = d;
    ParityEnable_i = pe;
    ParityResult_i = pr;
    DataValid_i    = 1'b1;
    k = 0;
    while (!DataReady_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 400) begin
      failures++;
      $display("FAIL hs_timeout: ready never seen for %h", d);
      DataValid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(build_frame(d, pe, pr));
    checks++;
    if (TxData_o !== d) begin
      failures++;
      $display("FAIL hs_txdata: got %h, expected %h", TxData_o, d);
    end
    checks++;
    if (DataReady_o !== 1'b0) begin
      failures++;
      $display("FAIL hs_ready_drop: got %b, expected 0", DataReady_o);
    end
    if (!keep_valid) begin
      @(negedge clk);
      DataValid_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= bound) begin
      failures++;
      $display("FAIL frame_timeout: %0d frames still expected after %0d clks", exp_q.size(), bound);
    end
  endtask

  task automatic test_reset;
    int k;
    rst = 1'b0;
    DataValid_i = 1'b0; Data_i = 8'h00; ParityEnable_i = 1'b0; ParityResult_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({State_o, Tx_o, DataReady_o, TxData_o, BitCounter_o, p_ParityCalTrigger_o, p_FrameDone_o}
        !== {ST_IDLE, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: state=%b tx=%b rdy=%b txd=%h bc=%0d trig=%b done=%b, expected 00001 1 0 00 0 0 0",
               State_o, Tx_o, DataReady_o, TxData_o, BitCounter_o, p_ParityCalTrigger_o, p_FrameDone_o);
    end
    rst = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
      checks++;
      if (DataReady_o !== 1'b0) begin
        failures++;
        $display("FAIL ready_before_idle: got %b, expected 0", DataReady_o);
      end
    end while (!p_BaudSig_i && k < 3 * DIV);
    @(posedge clk);
    #1;
    checks++;
    if (DataReady_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_idle: got %b, expected 1", DataReady_o);
    end
  endtask

  task automatic test_no_parity;
    handshake(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(400);
  endtask

  task automatic test_parity;
    handshake(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle(400);
  endtask

  task automatic test_back_to_back;
    int d0;
    handshake(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    d0 = done_count;
    handshake(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (done_count <= d0) begin
      failures++;
      $display("FAIL second_accept_early: done pulses %0d, expected > %0d", done_count, d0);
    end
    wait_idle(400);
  endtask

  task automatic test_coincident;
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(DataReady_o && p_BaudSig_i) && k < 4 * DIV);
    Data_i = 8'h6B; ParityEnable_i = 1'b0; ParityResult_i = 1'b0;
    DataValid_i = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(build_frame(8'h6B, 1'b0, 1'b0));
    checks++;
    if (State_o !== ST_IDLE || DataReady_o !== 1'b0) begin
      failures++;
      $display("FAIL coincident_hs: state=%b rdy=%b, expected 00001 0", State_o, DataReady_o);
    end
    @(negedge clk);
    DataValid_i = 1'b0;
    k = 1;
    while (State_o !== ST_STRT && k < 3 * DIV) begin
      @(posedge clk);
      #1;
      if (State_o !== ST_STRT) k++;
    end
    checks++;
    if (k !== DIV) begin
      failures++;
      $display("FAIL coincident_start: START after %0d clks, expected %0d", k, DIV);
    end
    wait_idle(400);
  endtask

  task automatic wait_in_data;
    int k;
    k = 0;
    while (State_o !== ST_DATA && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_parity_toggle;
    handshake(8'h96, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_in_data();
    ParityEnable_i = 1'b0;
    wait_idle(400);
    handshake(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_in_data();
    ParityEnable_i = 1'b1;
    wait_idle(400);
    ParityEnable_i = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int k, d0;
    handshake(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!(State_o === ST_DATA && BitCounter_o === 4'd4) && k < 300) begin
      @(negedge clk);
      k++;
    end
    d0 = done_count;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (Tx_o !== 1'b1 || State_o !== ST_IDLE || DataReady_o !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: tx=%b state=%b rdy=%b, expected 1 00001 0", Tx_o, State_o, DataReady_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (done_count !== d0) begin
      failures++;
      $display("FAIL abort_no_done: done pulses %0d, expected %0d", done_count, d0);
    end
    handshake(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(400);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_coincident();
    test_parity_toggle();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL leftover_frames: %0d still queued, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
